// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control FSM: fetch/decode/execute/memory/writeback with a timed memory handshake.
// Optional feature: define MULTICYCLE_CTRL_TRAP_EN to halt in TRAP on an illegal opcode.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] instr_opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic [2:0] imm_sel,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       bus_err,
  output logic       trap,
  output logic [2:0] state_o
);
  localparam int unsigned OP_W = 7;

  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_IMM = 2'd2;
  localparam logic [1:0] WB_PC4 = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t          state, state_n;
  logic [OP_W-1:0] op_q;
  logic [TO_W-1:0] cnt;
  logic            err_q;
  logic            req_act;
  logic            timeout;

  function automatic logic [2:0] imm_of(input logic [OP_W-1:0] op);
    case (op)
      OP_STORE:         imm_of = IMM_S;
      OP_BRANCH:        imm_of = IMM_B;
      OP_LUI, OP_AUIPC: imm_of = IMM_U;
      OP_JAL:           imm_of = IMM_J;
      default:          imm_of = IMM_I;
    endcase
  endfunction

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_R,
      OP_LOAD, OP_STORE, OP_BRANCH: is_legal = 1'b1;
      default:                      is_legal = 1'b0;
    endcase
  endfunction

  // The cycle after a timeout shows bus_err with the request dropped, then FETCH re-requests.
  assign req_act = ((state == S_FETCH) && !err_q) || (state == S_MEM);
  assign timeout = req_act && !mem_ready && (cnt == TO_W'(MEM_TIMEOUT - 1));
  assign mem_req = req_act;
  assign bus_err = err_q;
  assign state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= timeout;
      if (state == S_DECODE) op_q <= instr_opcode;
      if ((state_n != state) || timeout) cnt <= '0;
      else if (req_act && !mem_ready)    cnt <= cnt + TO_W'(1);
    end
  end

  // Next state and control decode from (state, op_q) plus the handshake terms.
  always_comb begin
    state_n      = state;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    imm_sel      = IMM_I;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    trap         = 1'b0;
    case (state)
      S_IDLE: state_n = S_FETCH;
      S_FETCH: begin
        if (req_act && mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        imm_sel = imm_of(instr_opcode);
        if (is_legal(instr_opcode)) begin
          state_n = S_EXEC;
        end else begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
          state_n = S_TRAP;
`else
          state_n = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        imm_sel = imm_of(op_q);
        case (op_q)
          OP_LOAD, OP_STORE: begin
            alu_b_sel = 1'b1;
            state_n   = S_MEM;
          end
          OP_BRANCH: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
            pc_we     = branch_taken;
            pc_src    = 1'b1;
            state_n   = S_FETCH;
          end
          OP_JAL: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
            pc_we     = 1'b1;
            pc_src    = 1'b1;
            reg_we    = 1'b1;
            wb_sel    = WB_PC4;
            state_n   = S_FETCH;
          end
          OP_R, OP_LUI, OP_AUIPC: state_n = S_WB;
          default:                state_n = S_FETCH;
        endcase
      end
      S_MEM: begin
        imm_sel      = imm_of(op_q);
        mem_addr_sel = 1'b1;
        mem_we       = (op_q == OP_STORE);
        if (mem_ready)    state_n = (op_q == OP_STORE) ? S_FETCH : S_WB;
        else if (timeout) state_n = S_FETCH;
      end
      S_WB: begin
        imm_sel = imm_of(op_q);
        reg_we  = 1'b1;
        state_n = S_FETCH;
        case (op_q)
          OP_LOAD: wb_sel = WB_MEM;
          OP_LUI:  wb_sel = WB_IMM;
          OP_AUIPC: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
          end
          default: wb_sel = WB_ALU;
        endcase
      end
      S_TRAP: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
        trap = 1'b1;
`else
        state_n = S_IDLE;
`endif
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control vectors queued as stimulus is driven.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = '0;
  logic       bt = 1'b0;
  logic       rdy = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src;
  logic [2:0] imm_sel;
  logic       alu_a_sel, alu_b_sel, reg_we;
  logic [1:0] wb_sel;
  logic       bus_err, trap;
  logic [2:0] state_o;

  multicycle_ctrl #(.MEM_TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .instr_opcode(op), .branch_taken(bt), .mem_ready(rdy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .imm_sel(imm_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .reg_we(reg_we), .wb_sel(wb_sel), .bus_err(bus_err),
    .trap(trap), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, asel, irwe, pcwe, pcsrc;
    logic [2:0] imm;
    logic       a, b, rwe;
    logic [1:0] wb;
    logic       berr, trp;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    logic       bt, rdy, rst;
    exp_t       want;
  } cyc_t;

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb[$];

  function automatic exp_t e(input int st, req, we, asel, irwe, pcwe, pcsrc, imm,
                             a, b, rwe, wb, berr, trp);
    e = {3'(st), 1'(req), 1'(we), 1'(asel), 1'(irwe), 1'(pcwe), 1'(pcsrc), 3'(imm),
         1'(a), 1'(b), 1'(rwe), 2'(wb), 1'(berr), 1'(trp)};
  endfunction

  function automatic exp_t idle_e();   return e(0, 0,0,0,0,0,0, 0, 0,0,0, 0, 0,0); endfunction
  function automatic exp_t f_ok();     return e(1, 1,0,0,1,1,0, 0, 0,0,0, 0, 0,0); endfunction
  function automatic exp_t f_wait();   return e(1, 1,0,0,0,0,0, 0, 0,0,0, 0, 0,0); endfunction
  function automatic exp_t dec(input int imm); return e(2, 0,0,0,0,0,0, imm, 0,0,0, 0, 0,0); endfunction

  function automatic cyc_t c(input logic [6:0] o, input int b, r, input exp_t w);
    c.op = o; c.bt = 1'(b); c.rdy = 1'(r); c.rst = 1'b1; c.want = w;
  endfunction

  function automatic cyc_t c_rst(input logic [6:0] o, input int b, r, input exp_t w);
    c_rst = c(o, b, r, w);
    c_rst.rst = 1'b0;
  endfunction

  function automatic exp_t observe();
    observe = {state_o, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, imm_sel,
               alu_a_sel, alu_b_sel, reg_we, wb_sel, bus_err, trap};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; op = '0; bt = 1'b0; rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cyc_t cy[$];
    exp_t got, want;
    cy.push_back(c_rst(OP_R, 1, 1, idle_e()));
    cy.push_back(c_rst(OP_R, 1, 1, idle_e()));
    cy.push_back(c(OP_R, 0, 1, idle_e()));
    cy.push_back(c(OP_R, 0, 1, f_ok()));
    foreach (cy[i]) begin
      rst_n = cy[i].rst; op = cy[i].op; bt = cy[i].bt; rdy = cy[i].rdy;
      sb.push_back(cy[i].want);
      #2;
      got = observe(); want = sb.pop_front(); n_chk++;
      if (got !== want) $display("FAIL reset cyc%0d got=%h want=%h", i, got, want);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_r_type();
    cyc_t cy[$];
    exp_t got, want;
    do_reset();
    cy.push_back(c(OP_R, 0, 1, idle_e()));
    cy.push_back(c(OP_R, 0, 1, f_ok()));
    cy.push_back(c(OP_R, 0, 1, dec(0)));
    cy.push_back(c(OP_R, 0, 1, e(3, 0,0,0,0,0,0, 0, 0,0,0, 0, 0,0)));
    cy.push_back(c(OP_R, 0, 1, e(5, 0,0,0,0,0,0, 0, 0,0,1, 0, 0,0)));
    cy.push_back(c(OP_R, 0, 1, f_ok()));
    foreach (cy[i]) begin
      rst_n = cy[i].rst; op = cy[i].op; bt = cy[i].bt; rdy = cy[i].rdy;
      sb.push_back(cy[i].want);
      #2;
      got = observe(); want = sb.pop_front(); n_chk++;
      if (got !== want) $display("FAIL r_type cyc%0d got=%h want=%h", i, got, want);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_load_wait();
    cyc_t cy[$];
    exp_t got, want;
    exp_t mem_e;
    do_reset();
    mem_e = e(4, 1,0,1,0,0,0, 0, 0,0,0, 0, 0,0);
    cy.push_back(c(OP_LOAD, 0, 1, idle_e()));
    cy.push_back(c(OP_LOAD, 0, 1, f_ok()));
    cy.push_back(c(OP_LOAD, 0, 1, dec(0)));
    cy.push_back(c(OP_LOAD, 0, 1, e(3, 0,0,0,0,0,0, 0, 0,1,0, 0, 0,0)));
    cy.push_back(c(OP_LOAD, 0, 0, mem_e));
    cy.push_back(c(OP_LOAD, 0, 0, mem_e));
    cy.push_back(c(OP_LOAD, 0, 1, mem_e));
    cy.push_back(c(OP_LOAD, 0, 1, e(5, 0,0,0,0,0,0, 0, 0,0,1, 1, 0,0)));
    cy.push_back(c(OP_LOAD, 0, 0, f_wait()));
    cy.push_back(c(OP_LOAD, 0, 1, f_ok()));
    foreach (cy[i]) begin
      rst_n = cy[i].rst; op = cy[i].op; bt = cy[i].bt; rdy = cy[i].rdy;
      sb.push_back(cy[i].want);
      #2;
      got = observe(); want = sb.pop_front(); n_chk++;
      if (got !== want) $display("FAIL load_wait cyc%0d got=%h want=%h", i, got, want);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    cyc_t cy[$];
    exp_t got, want;
    do_reset();
    cy.push_back(c(OP_BRANCH, 0, 1, idle_e()));
    cy.push_back(c(OP_BRANCH, 0, 1, f_ok()));
    cy.push_back(c(OP_BRANCH, 0, 1, dec(2)));
    cy.push_back(c(OP_BRANCH, 1, 1, e(3, 0,0,0,0,1,1, 2, 1,1,0, 0, 0,0)));
    cy.push_back(c(OP_BRANCH, 1, 1, f_ok()));
    cy.push_back(c(OP_BRANCH, 0, 1, dec(2)));
    cy.push_back(c(OP_BRANCH, 0, 1, e(3, 0,0,0,0,0,1, 2, 1,1,0, 0, 0,0)));
    cy.push_back(c(OP_BRANCH, 0, 1, f_ok()));
    foreach (cy[i]) begin
      rst_n = cy[i].rst; op = cy[i].op; bt = cy[i].bt; rdy = cy[i].rdy;
      sb.push_back(cy[i].want);
      #2;
      got = observe(); want = sb.pop_front(); n_chk++;
      if (got !== want) $display("FAIL branch cyc%0d got=%h want=%h", i, got, want);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_fetch_timeout();
    cyc_t cy[$];
    exp_t got, want;
    do_reset();
    cy.push_back(c(OP_R, 0, 0, idle_e()));
    for (int k = 0; k < 16; k++) cy.push_back(c(OP_R, 0, 0, f_wait()));
    cy.push_back(c(OP_R, 0, 0, e(1, 0,0,0,0,0,0, 0, 0,0,0, 0, 1,0)));
    cy.push_back(c(OP_R, 0, 0, f_wait()));
    cy.push_back(c(OP_R, 0, 1, f_ok()));
    cy.push_back(c(OP_R, 0, 1, dec(0)));
    foreach (cy[i]) begin
      rst_n = cy[i].rst; op = cy[i].op; bt = cy[i].bt; rdy = cy[i].rdy;
      sb.push_back(cy[i].want);
      #2;
      got = observe(); want = sb.pop_front(); n_chk++;
      if (got !== want) $display("FAIL fetch_timeout cyc%0d got=%h want=%h", i, got, want);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_ready_at_timeout();
    cyc_t cy[$];
    exp_t got, want;
    do_reset();
    cy.push_back(c(OP_R, 0, 0, idle_e()));
    for (int k = 0; k < 15; k++) cy.push_back(c(OP_R, 0, 0, f_wait()));
    cy.push_back(c(OP_R, 0, 1, f_ok()));
    cy.push_back(c(OP_R, 0, 0, dec(0)));
    foreach (cy[i]) begin
      rst_n = cy[i].rst; op = cy[i].op; bt = cy[i].bt; rdy = cy[i].rdy;
      sb.push_back(cy[i].want);
      #2;
      got = observe(); want = sb.pop_front(); n_chk++;
      if (got !== want) $display("FAIL ready_edge cyc%0d got=%h want=%h", i, got, want);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    cyc_t cy[$];
    exp_t got, want;
    do_reset();
    cy.push_back(c(OP_BAD, 0, 1, idle_e()));
    cy.push_back(c(OP_BAD, 0, 1, f_ok()));
    cy.push_back(c(OP_BAD, 0, 1, dec(0)));
`ifdef MULTICYCLE_CTRL_TRAP_EN
    for (int k = 0; k < 3; k++) cy.push_back(c(OP_BAD, 1, 1, e(6, 0,0,0,0,0,0, 0, 0,0,0, 0, 0,1)));
`else
    cy.push_back(c(OP_BAD, 0, 1, f_ok()));
    cy.push_back(c(OP_BAD, 0, 1, dec(0)));
    cy.push_back(c(OP_BAD, 0, 1, f_ok()));
`endif
    foreach (cy[i]) begin
      rst_n = cy[i].rst; op = cy[i].op; bt = cy[i].bt; rdy = cy[i].rdy;
      sb.push_back(cy[i].want);
      #2;
      got = observe(); want = sb.pop_front(); n_chk++;
      if (got !== want) $display("FAIL illegal cyc%0d got=%h want=%h", i, got, want);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    cyc_t cy[$];
    exp_t got, want;
    do_reset();
    cy.push_back(c(OP_JAL,   0, 1, idle_e()));
    cy.push_back(c(OP_JAL,   0, 1, f_ok()));
    cy.push_back(c(OP_JAL,   0, 1, dec(4)));
    cy.push_back(c(OP_JAL,   0, 1, e(3, 0,0,0,0,1,1, 4, 1,1,1, 3, 0,0)));
    cy.push_back(c(OP_JAL,   0, 1, f_ok()));
    cy.push_back(c(OP_AUIPC, 0, 1, dec(3)));
    cy.push_back(c(OP_AUIPC, 0, 1, e(3, 0,0,0,0,0,0, 3, 0,0,0, 0, 0,0)));
    cy.push_back(c(OP_AUIPC, 0, 1, e(5, 0,0,0,0,0,0, 3, 1,1,1, 0, 0,0)));
    cy.push_back(c(OP_AUIPC, 0, 1, f_ok()));
    cy.push_back(c(OP_LUI,   0, 1, dec(3)));
    cy.push_back(c(OP_LUI,   0, 1, e(3, 0,0,0,0,0,0, 3, 0,0,0, 0, 0,0)));
    cy.push_back(c(OP_LUI,   0, 1, e(5, 0,0,0,0,0,0, 3, 0,0,1, 2, 0,0)));
    cy.push_back(c(OP_LUI,   0, 1, f_ok()));
    cy.push_back(c(OP_STORE, 0, 1, dec(1)));
    cy.push_back(c(OP_STORE, 0, 1, e(3, 0,0,0,0,0,0, 1, 0,1,0, 0, 0,0)));
    cy.push_back(c(OP_STORE, 0, 1, e(4, 1,1,1,0,0,0, 1, 0,0,0, 0, 0,0)));
    cy.push_back(c(OP_STORE, 0, 1, f_ok()));
    foreach (cy[i]) begin
      rst_n = cy[i].rst; op = cy[i].op; bt = cy[i].bt; rdy = cy[i].rdy;
      sb.push_back(cy[i].want);
      #2;
      got = observe(); want = sb.pop_front(); n_chk++;
      if (got !== want) $display("FAIL back_to_back cyc%0d got=%h want=%h", i, got, want);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_store();
    cyc_t cy[$];
    exp_t got, want;
    do_reset();
    cy.push_back(c(OP_STORE, 0, 1, idle_e()));
    cy.push_back(c(OP_STORE, 0, 1, f_ok()));
    cy.push_back(c(OP_STORE, 0, 1, dec(1)));
    cy.push_back(c(OP_STORE, 0, 1, e(3, 0,0,0,0,0,0, 1, 0,1,0, 0, 0,0)));
    cy.push_back(c(OP_STORE, 0, 0, e(4, 1,1,1,0,0,0, 1, 0,0,0, 0, 0,0)));
    cy.push_back(c_rst(OP_STORE, 0, 1, idle_e()));
    cy.push_back(c_rst(OP_STORE, 0, 1, idle_e()));
    cy.push_back(c(OP_STORE, 0, 1, idle_e()));
    cy.push_back(c(OP_STORE, 0, 1, f_ok()));
    foreach (cy[i]) begin
      rst_n = cy[i].rst; op = cy[i].op; bt = cy[i].bt; rdy = cy[i].rdy;
      sb.push_back(cy[i].want);
      #2;
      got = observe(); want = sb.pop_front(); n_chk++;
      if (got !== want) $display("FAIL reset_mid_store cyc%0d got=%h want=%h", i, got, want);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_load_wait();
    test_branch();
    test_fetch_timeout();
    test_ready_at_timeout();
    test_illegal();
    test_back_to_back();
    test_reset_mid_store();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached, passed=%0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
